// File: rtl/disp_7seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table (active-low form)
// and the brightness sub-phase count.
package disp_7seg_pkg;
  localparam int SEG_W  = 7;
  localparam int PHASES = 16;

  // Bit order a,b,c,d,e,f,g from MSB to LSB; 0 lights a segment.
  localparam logic [SEG_W-1:0] GLYPH_0     = 7'b0000001;
  localparam logic [SEG_W-1:0] GLYPH_1     = 7'b1001111;
  localparam logic [SEG_W-1:0] GLYPH_2     = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_3     = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_4     = 7'b1001100;
  localparam logic [SEG_W-1:0] GLYPH_5     = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_6     = 7'b0100000;
  localparam logic [SEG_W-1:0] GLYPH_7     = 7'b0001111;
  localparam logic [SEG_W-1:0] GLYPH_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9     = 7'b0000100;
  localparam logic [SEG_W-1:0] GLYPH_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B     = 7'b1100000;
  localparam logic [SEG_W-1:0] GLYPH_C     = 7'b0110001;
  localparam logic [SEG_W-1:0] GLYPH_D     = 7'b1000010;
  localparam logic [SEG_W-1:0] GLYPH_E     = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_F     = 7'b0111000;
  localparam logic [SEG_W-1:0] GLYPH_DASH  = 7'b1111110;
  localparam logic [SEG_W-1:0] GLYPH_BLANK = 7'b1111111;

  // Converts an active-low glyph to the pin polarity of the board.
  function automatic logic [SEG_W-1:0] to_pol(input logic [SEG_W-1:0] glyph, input logic active_low);
    return active_low ? glyph : ~glyph;
  endfunction
endpackage

// File: rtl/disp_7seg_scan_if.sv
// Display bus between the BCD datapath (master) and the scan driver (slave).
interface disp_7seg_scan_if #(
  parameter int NUM_DIGITS = 4
);
  import disp_7seg_pkg::*;

  logic [4*NUM_DIGITS-1:0] bcd_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    blank_lz;
  logic [3:0]              bright;
  logic [SEG_W-1:0]        seg_out;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an_out;
  logic                    frame_pulse;

  modport master (
    output bcd_in, dp_in, blank_lz, bright,
    input  seg_out, dp_out, an_out, frame_pulse
  );

  modport slave (
    input  bcd_in, dp_in, blank_lz, bright,
    output seg_out, dp_out, an_out, frame_pulse
  );
endinterface

// File: rtl/disp_7seg_dec.sv
// Nibble to active-low seven-segment glyph; 10-15 fall back to a dash unless hex is enabled.
module disp_7seg_dec
  import disp_7seg_pkg::*;
(
  input  logic [3:0]       nib_i,
  input  logic             hex_en_i,
  output logic [SEG_W-1:0] glyph_o
);
  always_comb begin
    glyph_o = GLYPH_DASH;
    case (nib_i)
      4'h0: glyph_o = GLYPH_0;
      4'h1: glyph_o = GLYPH_1;
      4'h2: glyph_o = GLYPH_2;
      4'h3: glyph_o = GLYPH_3;
      4'h4: glyph_o = GLYPH_4;
      4'h5: glyph_o = GLYPH_5;
      4'h6: glyph_o = GLYPH_6;
      4'h7: glyph_o = GLYPH_7;
      4'h8: glyph_o = GLYPH_8;
      4'h9: glyph_o = GLYPH_9;
      4'hA: glyph_o = hex_en_i ? GLYPH_A : GLYPH_DASH;
      4'hB: glyph_o = hex_en_i ? GLYPH_B : GLYPH_DASH;
      4'hC: glyph_o = hex_en_i ? GLYPH_C : GLYPH_DASH;
      4'hD: glyph_o = hex_en_i ? GLYPH_D : GLYPH_DASH;
      4'hE: glyph_o = hex_en_i ? GLYPH_E : GLYPH_DASH;
      4'hF: glyph_o = hex_en_i ? GLYPH_F : GLYPH_DASH;
      default: glyph_o = GLYPH_DASH;
    endcase
  end
endmodule

// File: rtl/disp_7seg_scan.sv
// Time-multiplexed seven-segment driver: frame-latched digits, PWM brightness,
// leading-zero blanking and configurable pin polarity.
module disp_7seg_scan
  import disp_7seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 1000,
  parameter int HEX_EN         = 0,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic               clk,
  input  logic               rst,
  disp_7seg_scan_if.slave    disp_if
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DIG_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_W = 4 * NUM_DIGITS;

  localparam logic                  SEG_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic                  AN_LOW  = (AN_ACTIVE_LOW != 0);
  localparam logic [SEG_W-1:0]      SEG_RST = to_pol(GLYPH_DASH, SEG_LOW);
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_LOW}};

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            phase_q, phase_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [BCD_W-1:0]      shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0] dp_shadow_q, dp_shadow_d;
  logic                  valid_q, valid_d;
  logic                  frame_pulse_q, frame_pulse_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  logic tick, phase_wrap, digit_wrap;

  assign tick       = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign phase_wrap = tick && (phase_q == 4'(PHASES - 1));
  assign digit_wrap = phase_wrap && (digit_q == DIG_W'(NUM_DIGITS - 1));

  // The shadow word only moves at a frame boundary, so a frame never mixes two inputs.
  always_comb begin
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    phase_d       = tick ? phase_q + 4'd1 : phase_q;
    digit_d       = digit_q;
    shadow_d      = shadow_q;
    dp_shadow_d   = dp_shadow_q;
    valid_d       = valid_q;
    frame_pulse_d = digit_wrap;
    if (phase_wrap) begin
      digit_d = digit_wrap ? '0 : digit_q + 1'b1;
    end
    if (digit_wrap) begin
      shadow_d    = disp_if.bcd_in;
      dp_shadow_d = disp_if.dp_in;
      valid_d     = 1'b1;
    end
  end

  logic [3:0]            nib_arr [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] nib_zero;
  logic [NUM_DIGITS-1:0] lead_zero;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
    assign nib_arr[gi]  = shadow_q[4*gi +: 4];
    assign nib_zero[gi] = (shadow_q[4*gi +: 4] == 4'h0);
  end

  // lead_zero[k]: every nibble from k up to the most significant digit is zero.
  always_comb begin : lz_scan
    logic upper_zero;
    upper_zero = 1'b1;
    lead_zero  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero   = upper_zero & nib_zero[i];
      lead_zero[i] = upper_zero;
    end
  end

  logic [3:0]            nib_cur;
  logic [SEG_W-1:0]      glyph_raw, glyph_sel;
  logic                  blank_cur, dp_on;
  logic [NUM_DIGITS-1:0] an_on;

  assign nib_cur = nib_arr[digit_q];

  disp_7seg_dec u_dec (
    .nib_i    (nib_cur),
    .hex_en_i (HEX_EN != 0),
    .glyph_o  (glyph_raw)
  );

  always_comb begin
    blank_cur = disp_if.blank_lz && valid_q && (digit_q != '0) && lead_zero[digit_q];
    glyph_sel = glyph_raw;
    if (!valid_q) begin
      glyph_sel = GLYPH_DASH;
    end else if (blank_cur) begin
      glyph_sel = GLYPH_BLANK;
    end
    seg_d = to_pol(glyph_sel, SEG_LOW);
    dp_on = valid_q && dp_shadow_q[digit_q];
    dp_d  = SEG_LOW ? ~dp_on : dp_on;
    an_on = '0;
    if (phase_q <= disp_if.bright) begin
      an_on[digit_q] = 1'b1;
    end
    an_d = AN_LOW ? ~an_on : an_on;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      phase_q       <= '0;
      digit_q       <= '0;
      shadow_q      <= '0;
      dp_shadow_q   <= '0;
      valid_q       <= 1'b0;
      frame_pulse_q <= 1'b0;
      seg_q         <= SEG_RST;
      dp_q          <= SEG_LOW;
      an_q          <= AN_OFF;
    end else begin
      cnt_q         <= cnt_d;
      phase_q       <= phase_d;
      digit_q       <= digit_d;
      shadow_q      <= shadow_d;
      dp_shadow_q   <= dp_shadow_d;
      valid_q       <= valid_d;
      frame_pulse_q <= frame_pulse_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
    end
  end

  assign disp_if.seg_out     = seg_q;
  assign disp_if.dp_out      = dp_q;
  assign disp_if.an_out      = an_q;
  assign disp_if.frame_pulse = frame_pulse_q;
endmodule

// File: tb/tb_disp_7seg_scan.sv
// Directed bench: three driver variants (default, hex glyphs, active-high pins) on shared stimulus.
module tb_disp_7seg_scan;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd = 16'h1234;
  logic [3:0]  dp = 4'b0100;
  logic        blz = 1'b0;
  logic [3:0]  bright = 4'd15;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] exp_seg [4];
  logic [3:0] exp_dp;
  int         cyc;

  always #5 clk = ~clk;

  disp_7seg_scan_if #(.NUM_DIGITS(4)) bus_a ();
  disp_7seg_scan_if #(.NUM_DIGITS(4)) bus_h ();
  disp_7seg_scan_if #(.NUM_DIGITS(4)) bus_p ();

  assign bus_a.bcd_in = bcd;  assign bus_a.dp_in = dp;  assign bus_a.blank_lz = blz;  assign bus_a.bright = bright;
  assign bus_h.bcd_in = bcd;  assign bus_h.dp_in = dp;  assign bus_h.blank_lz = blz;  assign bus_h.bright = bright;
  assign bus_p.bcd_in = bcd;  assign bus_p.dp_in = dp;  assign bus_p.blank_lz = blz;  assign bus_p.bright = bright;

  disp_7seg_scan #(.NUM_DIGITS(4), .TICK_DIV(2)) dut_a (.clk(clk), .rst(rst), .disp_if(bus_a));
  disp_7seg_scan #(.NUM_DIGITS(4), .TICK_DIV(2), .HEX_EN(1)) dut_h (.clk(clk), .rst(rst), .disp_if(bus_h));
  disp_7seg_scan #(.NUM_DIGITS(4), .TICK_DIV(2), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0))
    dut_p (.clk(clk), .rst(rst), .disp_if(bus_p));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_exp(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                         input logic [6:0] s0, input logic [3:0] dpv);
    exp_seg[3] = s3; exp_seg[2] = s2; exp_seg[1] = s1; exp_seg[0] = s0;
    exp_dp = dpv;
  endtask

  // Returns at the negedge where frame_pulse is seen; cycles counts negedges waited.
  task automatic wait_frame(input bit chk_dash, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 400 && !seen; i++) begin
      @(negedge clk);
      cycles = i;
      if (chk_dash) begin
        check("pre_seg", bus_a.seg_out, 7'b1111110);
        check("pre_dp", bus_a.dp_out, 1'b1);
      end
      seen = bus_a.frame_pulse;
    end
    check("frame_seen", bus_a.frame_pulse, 1'b1);
    $display("frame pulse after %0d cycles", cycles);
  endtask

  // Checks one whole frame starting right after a frame_pulse negedge.
  task automatic scan_frame(input string name, input int chg_at, input logic [15:0] chg_val);
    int         dig, ph;
    logic [3:0] an_exp;
    for (int j = 0; j < 128; j++) begin
      @(negedge clk);
      dig = j / 32;
      ph  = (j % 32) / 2;
      an_exp = (ph <= int'(bright)) ? ~(4'b0001 << dig) : 4'hF;
      check($sformatf("%s_seg_d%0d", name, dig), bus_a.seg_out, exp_seg[dig]);
      check($sformatf("%s_dp_d%0d", name, dig), bus_a.dp_out, exp_dp[dig]);
      check($sformatf("%s_an_j%0d", name, j), bus_a.an_out, an_exp);
      check($sformatf("%s_fp_j%0d", name, j), bus_a.frame_pulse, (j == 127));
      if (j == chg_at) bcd = chg_val;
    end
    $display("frame %s: bcd_in=%h bright=%0d blank_lz=%0b checked", name, bcd, bright, blz);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_seg", bus_a.seg_out, 7'b1111110);
    check("rst_dp", bus_a.dp_out, 1'b1);
    check("rst_an", bus_a.an_out, 4'b1111);
    check("rst_fp", bus_a.frame_pulse, 1'b0);
    rst = 1'b0;
    wait_frame(1'b1, cyc);
    check("first_frame_cycles", cyc, 128);

    // Plain digits, full brightness, then reduced PWM duty
    set_exp(7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 4'b1011);
    scan_frame("d1234", -1, 16'h0);
    bright = 4'd3;
    scan_frame("bright3", -1, 16'h0);
    bright = 4'd0;
    scan_frame("bright0", -1, 16'h0);
    bright = 4'd15;

    // Mid-frame input change stays invisible until the next reload
    scan_frame("hold", 40, 16'h9999);
    set_exp(7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100, 4'b1011);
    scan_frame("d9999", -1, 16'h0);

    // Leading-zero blanking (dp still shown on a blanked digit)
    blz = 1'b1; bcd = 16'h0056;
    wait_frame(1'b0, cyc);
    set_exp(7'b1111111, 7'b1111111, 7'b0100100, 7'b0100000, 4'b1011);
    scan_frame("lz0056", -1, 16'h0);
    bcd = 16'h0000;
    wait_frame(1'b0, cyc);
    set_exp(7'b1111111, 7'b1111111, 7'b1111111, 7'b0000001, 4'b1011);
    scan_frame("lz0000", -1, 16'h0);
    bcd = 16'hA000;
    wait_frame(1'b0, cyc);
    set_exp(7'b1111110, 7'b0000001, 7'b0000001, 7'b0000001, 4'b1011);
    scan_frame("lzA000", -1, 16'h0);

    // Hex glyphs and inverted polarity
    blz = 1'b0; bcd = 16'h008A; dp = 4'b0000;
    wait_frame(1'b0, cyc);
    @(negedge clk);
    check("hex0_seg_a", bus_a.seg_out, 7'b1111110);
    check("hex0_seg_h", bus_h.seg_out, 7'b0001000);
    check("hex0_seg_p", bus_p.seg_out, 7'b0000001);
    check("hex0_an_p", bus_p.an_out, 4'b0001);
    repeat (32) @(negedge clk);
    check("hex1_seg_h", bus_h.seg_out, 7'b0000000);
    check("hex1_seg_p", bus_p.seg_out, 7'b1111111);
    check("hex1_an_p", bus_p.an_out, 4'b0010);
    check("hex1_dp_p", bus_p.dp_out, 1'b0);
    $display("hex/polarity: bcd_in=%h checked", bcd);

    // Asynchronous reset mid-slot, then restart from digit 0
    bcd = 16'h9999; dp = 4'b0100;
    wait_frame(1'b0, cyc);
    repeat (45) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_seg", bus_a.seg_out, 7'b1111110);
    check("arst_dp", bus_a.dp_out, 1'b1);
    check("arst_an", bus_a.an_out, 4'b1111);
    check("arst_fp", bus_a.frame_pulse, 1'b0);
    check("arst_an_p", bus_p.an_out, 4'b0000);
    #1 rst = 1'b0;
    wait_frame(1'b1, cyc);
    check("restart_cycles", cyc, 128);
    set_exp(7'b0000100, 7'b0000100, 7'b0000100, 7'b0000100, 4'b1011);
    scan_frame("restart", -1, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
